// File: rtl/addi_fuser_pkg.sv
// Shared types and decode helpers for the addi run fuser.
// Build option ADDI_FUSER_CONF_EN adds a per-entry confidence counter.
package addi_fuser_pkg;

  localparam logic [4:0] OP_IMM      = 5'b00100;
  localparam logic [2:0] FUNCT3_ADDI = 3'b000;

  // Entry fields are sized for the widest supported configuration
  localparam int unsigned TAG_MAX_W   = 30;
  localparam int unsigned WADDR_MAX_W = 30;
  localparam int unsigned LEN_MAX_W   = 8;

  typedef enum logic {S_IDLE, S_CHAIN} state_e;

  typedef struct packed {
    logic [TAG_MAX_W-1:0]   tag;
    logic [4:0]             rd;
    logic [31:0]            sum;
    logic [WADDR_MAX_W-1:0] end_waddr;
    logic [LEN_MAX_W-1:0]   len;
`ifdef ADDI_FUSER_CONF_EN
    logic [1:0]             conf;
`endif
  } entry_t;

  // addi rd,rd,imm with a nonzero destination
  function automatic logic is_fusible(input logic [31:0] ir);
    return (ir[6:2] == OP_IMM) && (ir[14:12] == FUNCT3_ADDI) &&
           (ir[11:7] == ir[19:15]) && (ir[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] i_imm(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

endpackage

// File: rtl/addi_fuser_table.sv
// Direct-mapped run table: async-clear valid bits, one write port, one combinational read port.
// With ADDI_FUSER_CONF_EN the confidence counter is updated here on write.
module addi_fuser_table
  import addi_fuser_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_flush,
  input  logic             w_we,
  input  logic [IDX_W-1:0] w_widx,
  input  entry_t           w_wdata,
  input  logic [IDX_W-1:0] w_ridx,
  output logic             w_rvld,
  output entry_t           w_rdata
);

  logic [ENTRIES-1:0] vld_q;
  entry_t             mem_q [ENTRIES];
  entry_t             wr_c;

  // Flush wins over a simultaneous write
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst)        vld_q <= '0;
    else if (w_flush) vld_q <= '0;
    else if (w_we)    vld_q[w_widx] <= 1'b1;
  end

`ifdef ADDI_FUSER_CONF_EN
  logic same_c;

  // Re-learning the identical run builds confidence; anything else restarts it
  always_comb begin
    wr_c   = w_wdata;
    same_c = vld_q[w_widx] &&
             (mem_q[w_widx].tag == w_wdata.tag) &&
             (mem_q[w_widx].sum == w_wdata.sum) &&
             (mem_q[w_widx].end_waddr == w_wdata.end_waddr);
    if (same_c)
      wr_c.conf = (mem_q[w_widx].conf == 2'd3) ? 2'd3 : mem_q[w_widx].conf + 2'd1;
  end
`else
  always_comb begin
    wr_c = w_wdata;
  end
`endif

  always_ff @(posedge w_clk) begin
    if (w_we) mem_q[w_widx] <= wr_c;
  end

  assign w_rvld  = vld_q[w_ridx];
  assign w_rdata = mem_q[w_ridx];

endmodule

// File: rtl/m_addi_fuser.sv
// Learns runs of addi rd,rd,imm from retirement and fuses them at Ex lookup.
// Build option ADDI_FUSER_CONF_EN gates hits on a 2-bit confidence counter.
module m_addi_fuser
  import addi_fuser_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned MIN_LEN = 3,
  parameter int unsigned MAX_LEN = 15
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_lk_vld,
  input  logic [31:0] w_lk_ir,
  input  logic [31:0] w_lk_pc,
  output logic        w_hit,
  output logic [31:0] w_imm,
  output logic [31:0] w_npc,
  input  logic        w_tr_vld,
  input  logic [31:0] w_tr_ir,
  input  logic [31:0] w_tr_pc,
  input  logic        w_flush,
  output logic [31:0] w_hits
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  state_e           state_q, state_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      sum_q, sum_d, last_q, last_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] sidx_q, sidx_d;
  logic [TAG_W-1:0] stag_q, stag_d;
  logic [31:0]      hits_q;

  logic        commit_c, tr_fus_c, tr_ext_c, hit_c, ent_vld_c;
  logic [31:0] tr_imm_c;
  entry_t      wdata_c, ent_c;
  logic        unused_lk_pc;

  assign unused_lk_pc = &{1'b0, w_lk_pc[31:ADDR_W+2], w_lk_pc[1:0]};

  assign tr_fus_c = is_fusible(w_tr_ir);
  assign tr_imm_c = i_imm(w_tr_ir);
  assign tr_ext_c = tr_fus_c && (w_tr_ir[11:7] == rd_q) &&
                    (w_tr_pc == last_q + 32'd4) && (len_q < LEN_W'(MAX_LEN));

  // Training FSM: extend the open run or close it (committing if long enough)
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    sum_d    = sum_q;
    len_d    = len_q;
    last_d   = last_q;
    sidx_d   = sidx_q;
    stag_d   = stag_q;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_tr_vld && tr_fus_c) begin
          state_d = S_CHAIN;
          rd_d    = w_tr_ir[11:7];
          sum_d   = tr_imm_c;
          len_d   = LEN_W'(1);
          last_d  = w_tr_pc;
          sidx_d  = w_tr_pc[IDX_W+1:2];
          stag_d  = w_tr_pc[ADDR_W+1:IDX_W+2];
        end
      end
      S_CHAIN: begin
        if (w_tr_vld) begin
          if (tr_ext_c) begin
            sum_d  = sum_q + tr_imm_c;
            len_d  = len_q + LEN_W'(1);
            last_d = w_tr_pc;
          end else begin
            commit_c = (32'(len_q) >= MIN_LEN);
            if (tr_fus_c) begin
              rd_d   = w_tr_ir[11:7];
              sum_d  = tr_imm_c;
              len_d  = LEN_W'(1);
              last_d = w_tr_pc;
              sidx_d = w_tr_pc[IDX_W+1:2];
              stag_d = w_tr_pc[ADDR_W+1:IDX_W+2];
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_flush) begin
      state_d  = S_IDLE;
      commit_c = 1'b0;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      sum_q   <= '0;
      len_q   <= '0;
      last_q  <= '0;
      sidx_q  <= '0;
      stag_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      last_q  <= last_d;
      sidx_q  <= sidx_d;
      stag_q  <= stag_d;
    end
  end

  always_comb begin
    wdata_c           = '0;
    wdata_c.tag       = TAG_MAX_W'(stag_q);
    wdata_c.rd        = rd_q;
    wdata_c.sum       = sum_q;
    wdata_c.end_waddr = WADDR_MAX_W'(last_q[ADDR_W+1:2]);
    wdata_c.len       = LEN_MAX_W'(len_q);
`ifdef ADDI_FUSER_CONF_EN
    wdata_c.conf      = 2'd1;
`endif
  end

  addi_fuser_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_table (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_flush (w_flush),
    .w_we    (commit_c),
    .w_widx  (sidx_q),
    .w_wdata (wdata_c),
    .w_ridx  (w_lk_pc[IDX_W+1:2]),
    .w_rvld  (ent_vld_c),
    .w_rdata (ent_c)
  );

  always_comb begin
    hit_c = w_lk_vld && is_fusible(w_lk_ir) && ent_vld_c &&
            (ent_c.tag == TAG_MAX_W'(w_lk_pc[ADDR_W+1:IDX_W+2])) &&
            (ent_c.rd == w_lk_ir[11:7]) && (32'(ent_c.len) >= MIN_LEN);
`ifdef ADDI_FUSER_CONF_EN
    hit_c = hit_c && (ent_c.conf >= 2'd2);
`endif
  end

  assign w_hit = hit_c;
  assign w_imm = hit_c ? ent_c.sum : 32'd0;
  assign w_npc = hit_c ? (32'({ent_c.end_waddr, 2'b00}) + 32'd4) : 32'd0;

  // Saturating hit counter; survives flush
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst)                       hits_q <= '0;
    else if (hit_c && hits_q != '1)  hits_q <= hits_q + 32'd1;
  end

  assign w_hits = hits_q;

endmodule

// File: tb/tb_m_addi_fuser.sv
// Directed bench for m_addi_fuser; expected outputs flow through a scoreboard queue.
module tb_m_addi_fuser;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_lk_vld = 1'b0, w_tr_vld = 1'b0, w_flush = 1'b0;
  logic [31:0] w_lk_ir = '0, w_lk_pc = '0, w_tr_ir = '0, w_tr_pc = '0;
  logic        w_hit;
  logic [31:0] w_imm, w_npc, w_hits;

`ifdef ADDI_FUSER_CONF_EN
  localparam int REPS = 2;
`else
  localparam int REPS = 1;
`endif

  typedef struct packed {
    logic        hit;
    logic [31:0] imm;
    logic [31:0] npc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_hits = 0;

  m_addi_fuser dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_lk_vld(w_lk_vld), .w_lk_ir(w_lk_ir), .w_lk_pc(w_lk_pc),
    .w_hit(w_hit), .w_imm(w_imm), .w_npc(w_npc),
    .w_tr_vld(w_tr_vld), .w_tr_ir(w_tr_ir), .w_tr_pc(w_tr_pc),
    .w_flush(w_flush), .w_hits(w_hits)
  );

  always #5 w_clk = ~w_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] addi_rs(input logic [4:0] rd, input logic [4:0] rs, input logic [11:0] imm);
    return {imm, rs, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return addi_rs(rd, rd, imm);
  endfunction

  function automatic logic [31:0] add_rr(input logic [4:0] rd);
    return {7'd0, rd, rd, 3'b000, rd, 7'h33};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic eh, input logic [31:0] eimm, input logic [31:0] enpc);
    exp_t e;
    e.hit = eh;
    e.imm = eh ? eimm : 32'd0;
    e.npc = eh ? enpc : 32'd0;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL %s: scoreboard empty got 0 expected 1", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, " hit"}, 32'(w_hit), 32'(e.hit));
      chk({tag, " imm"}, w_imm, e.imm);
      chk({tag, " npc"}, w_npc, e.npc);
    end
  endtask

  // One cycle: drive both stages at negedge, compare before the next posedge
  task automatic step(input string tag, input logic fl,
                      input logic tv, input logic [31:0] tir, input logic [31:0] tpc,
                      input logic lv, input logic [31:0] lir, input logic [31:0] lpc,
                      input logic eh, input logic [31:0] eimm, input logic [31:0] enpc);
    @(negedge w_clk);
    w_flush = fl; w_tr_vld = tv; w_tr_ir = tir; w_tr_pc = tpc;
    w_lk_vld = lv; w_lk_ir = lir; w_lk_pc = lpc;
    push_exp(eh, eimm, enpc);
    #2;
    pop_cmp(tag);
    chk({tag, " hits"}, w_hits, 32'(exp_hits));
    if (eh) exp_hits++;
  endtask

  task automatic retire(input string tag, input logic [31:0] ir, input logic [31:0] pc);
    step(tag, 1'b0, 1'b1, ir, pc, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic bubble(input string tag);
    step(tag, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic lookup(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                        input logic eh, input logic [31:0] eimm, input logic [31:0] enpc);
    step(tag, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, ir, pc, eh, eimm, enpc);
  endtask

  initial begin
    // Reset state with a lookup already presented
    lookup("reset", addi(5, 12'd1), 32'h10, 1'b0, 32'd0, 32'd0);
    @(negedge w_clk);
    w_rst = 1'b0;

    // Basic run of three, same-cycle lookup sees the old (empty) entry
    for (int r = 0; r < REPS; r++) begin
      retire("t1 a0", addi(5, 12'd1), 32'h10);
      retire("t1 a1", addi(5, 12'd1), 32'h14);
      retire("t1 a2", addi(5, 12'd1), 32'h18);
      step("t1 samecyc", 1'b0, 1'b1, add_rr(5), 32'h1C, 1'b1, addi(5, 12'd1), 32'h10, 1'b0, 32'd0, 32'd0);
    end
    lookup("t1 hit", addi(5, 12'd1), 32'h10, 1'b1, 32'd3, 32'h1C);
    lookup("t1 rdmis", addi(6, 12'd1), 32'h10, 1'b0, 32'd0, 32'd0);
    step("t1 novld", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, addi(5, 12'd1), 32'h10, 1'b0, 32'd0, 32'd0);
    lookup("t1 nonfus", add_rr(5), 32'h10, 1'b0, 32'd0, 32'd0);
    lookup("t1 idx", addi(5, 12'd1), 32'h14, 1'b0, 32'd0, 32'd0);

    // Too short to commit
    retire("t2 a0", addi(6, 12'd1), 32'h40);
    retire("t2 a1", addi(6, 12'd1), 32'h44);
    retire("t2 end", add_rr(6), 32'h48);
    lookup("t2 miss", addi(6, 12'd1), 32'h40, 1'b0, 32'd0, 32'd0);

    // Length cap at 15, overflow instruction starts the next run
    for (int r = 0; r < REPS; r++) begin
      for (int i = 0; i < 20; i++) retire("t3 run", addi(7, 12'd2), 32'h100 + 32'(4 * i));
      retire("t3 end", add_rr(7), 32'h150);
    end
    lookup("t3 cap", addi(7, 12'd2), 32'h100, 1'b1, 32'd30, 32'h13C);
    lookup("t3 next", addi(7, 12'd2), 32'h13C, 1'b1, 32'd10, 32'h150);
    lookup("t3 mid", addi(7, 12'd2), 32'h104, 1'b0, 32'd0, 32'd0);

    // Signed immediates wrap mod 2^32; bubbles do not break the run
    for (int r = 0; r < REPS; r++) begin
      retire("t4 a0", addi(8, 12'h800), 32'h220);
      bubble("t4 b0");
      retire("t4 a1", addi(8, 12'h7FF), 32'h224);
      bubble("t4 b1");
      bubble("t4 b2");
      retire("t4 a2", addi(8, 12'hFFF), 32'h228);
      retire("t4 end", addi_rs(9, 8, 12'd1), 32'h22C);
    end
    lookup("t4 wrap", addi(8, 12'd5), 32'h220, 1'b1, 32'hFFFFFFFE, 32'h22C);

    // Aliasing run overwrites index 4; tag and rd mismatches miss
    for (int r = 0; r < REPS; r++) begin
      retire("t5 a0", addi(5, 12'd3), 32'h50);
      retire("t5 a1", addi(5, 12'd3), 32'h54);
      retire("t5 a2", addi(5, 12'd3), 32'h58);
      retire("t5 end", add_rr(5), 32'h5C);
    end
    lookup("t5 oldtag", addi(5, 12'd1), 32'h10, 1'b0, 32'd0, 32'd0);
    lookup("t5 hit", addi(5, 12'd1), 32'h50, 1'b1, 32'd9, 32'h5C);
    lookup("t5 rdmis", addi(6, 12'd1), 32'h50, 1'b0, 32'd0, 32'd0);

    // Flush together with a commit: everything misses, hit count kept
    retire("t6 a0", addi(10, 12'd1), 32'h300);
    retire("t6 a1", addi(10, 12'd1), 32'h304);
    retire("t6 a2", addi(10, 12'd1), 32'h308);
    step("t6 flush", 1'b1, 1'b1, add_rr(10), 32'h30C, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    lookup("t6 new", addi(10, 12'd1), 32'h300, 1'b0, 32'd0, 32'd0);
    lookup("t6 e100", addi(7, 12'd2), 32'h100, 1'b0, 32'd0, 32'd0);
    lookup("t6 e13c", addi(7, 12'd2), 32'h13C, 1'b0, 32'd0, 32'd0);
    lookup("t6 e50", addi(5, 12'd1), 32'h50, 1'b0, 32'd0, 32'd0);
    lookup("t6 e220", addi(8, 12'd1), 32'h220, 1'b0, 32'd0, 32'd0);

    // Async reset mid-run, between clock edges
    for (int r = 0; r < REPS; r++) begin
      retire("t7 a0", addi(5, 12'd1), 32'h10);
      retire("t7 a1", addi(5, 12'd1), 32'h14);
      retire("t7 a2", addi(5, 12'd1), 32'h18);
      retire("t7 end", add_rr(5), 32'h1C);
    end
    retire("t7 r0", addi(5, 12'd1), 32'h80);
    retire("t7 r1", addi(5, 12'd1), 32'h84);
    retire("t7 r2", addi(5, 12'd1), 32'h88);
    @(negedge w_clk);
    w_tr_vld = 1'b0; w_flush = 1'b0;
    w_lk_vld = 1'b1; w_lk_ir = addi(5, 12'd1); w_lk_pc = 32'h10;
    push_exp(1'b1, 32'd3, 32'h1C);
    #2;
    pop_cmp("t7 prerst");
    chk("t7 prerst hits", w_hits, 32'(exp_hits));
    #1;
    w_rst = 1'b1;
    push_exp(1'b0, 32'd0, 32'd0);
    #1;
    pop_cmp("t7 inrst");
    exp_hits = 0;
    chk("t7 inrst hits", w_hits, 32'(exp_hits));
    @(negedge w_clk);
    w_rst = 1'b0;
    retire("t7 term", add_rr(5), 32'h8C);
    lookup("t7 nopart", addi(5, 12'd1), 32'h80, 1'b0, 32'd0, 32'd0);
    lookup("t7 cleared", addi(5, 12'd1), 32'h10, 1'b0, 32'd0, 32'd0);

    // Training resumes normally after reset
    for (int r = 0; r < REPS; r++) begin
      retire("t8 a0", addi(11, 12'd4), 32'h400);
      retire("t8 a1", addi(11, 12'd4), 32'h404);
      retire("t8 a2", addi(11, 12'd4), 32'h408);
      retire("t8 a3", addi(11, 12'd4), 32'h40C);
      retire("t8 end", add_rr(11), 32'h410);
    end
    lookup("t8 hit", addi(11, 12'd4), 32'h400, 1'b1, 32'd16, 32'h410);
    bubble("t8 final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
